// File: rtl/lc_ctrl_pkg.sv
// Life-cycle multibit signal encodings shared by the lc sync/filter blocks.
package lc_ctrl_pkg;

  localparam int unsigned TxWidth = 4;

  typedef logic [TxWidth-1:0] lc_tx_t;

  // Complementary, non-adjacent encodings so single-bit upsets never map On<->Off.
  localparam lc_tx_t On  = 4'b0101;
  localparam lc_tx_t Off = 4'b1010;

  // True only for the two legal encodings; everything else is a fault.
  function automatic logic lc_tx_valid(lc_tx_t val);
    return (val == On) || (val == Off);
  endfunction

endpackage

// File: rtl/caliptra_prim_lc_sync_2flop.sv
// Two-stage synchronizer for a multibit signal arriving from another clock domain.
module caliptra_prim_lc_sync_2flop #(
  parameter int unsigned      Width      = 4,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] sync1_q;
  logic [Width-1:0] sync2_q;

  // Both stages reset to the same value so reset never looks like an input change.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= ResetValue;
      sync2_q <= ResetValue;
    end else begin
      sync1_q <= d;
      sync2_q <= sync1_q;
    end
  end

  assign q = sync2_q;

endmodule

// File: rtl/caliptra_prim_sec_anchor_buf.sv
// Buffer marking a net that implementation tools must keep and not merge.
module caliptra_prim_sec_anchor_buf #(
  parameter int unsigned Width = 1
) (
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout
);

  // Plain pass-through in RTL; the cell is swapped for a keep-buffer in implementation.
  assign dout = din;

endmodule

// File: rtl/caliptra_prim_lc_sync_filt.sv
// Synchronizes a life-cycle multibit enable, then only accepts a value that has
// been stable for FiltCycles synchronized cycles. Invalid encodings fail safe to Off.
module caliptra_prim_lc_sync_filt
  import lc_ctrl_pkg::*;
#(
  parameter int unsigned NumCopies      = 1,
  parameter int unsigned FiltCycles     = 4,
  parameter bit          ResetValueIsOn = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  lc_tx_t                 lc_en_i,
  output lc_tx_t [NumCopies-1:0] lc_en_o,
  output logic                   err_o,
  output logic                   chg_o
);

  if (FiltCycles < 1) begin : gen_filt_cycles_chk
    $error("FiltCycles must be at least 1");
  end
  if (NumCopies < 1) begin : gen_num_copies_chk
    $error("NumCopies must be at least 1");
  end

  localparam lc_tx_t          ResetValue = ResetValueIsOn ? On : Off;
  localparam int unsigned     CntW       = $clog2(FiltCycles + 1);
  localparam logic [CntW-1:0] CntMax     = CntW'(FiltCycles - 1);

  typedef enum logic [1:0] {
    StIdle,
    StFilt,
    StErr
  } state_e;

  lc_tx_t          sync2;
  lc_tx_t          cand_q;
  lc_tx_t          acc_q;
  logic [CntW-1:0] cnt_q;
  state_e          state_q;
  logic            err_q;
  logic            chg_q;

  caliptra_prim_lc_sync_2flop #(
    .Width      (TxWidth),
    .ResetValue (ResetValue)
  ) u_sync (
    .clk (clk_i),
    .rst (rst_i),
    .d   (lc_en_i),
    .q   (sync2)
  );

  // Filter FSM: any mismatch restarts the count, so only a run of FiltCycles equal
  // samples is accepted. err/chg are registered alongside the accepted value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cand_q  <= ResetValue;
      acc_q   <= ResetValue;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      chg_q <= 1'b0;
      if (sync2 != cand_q) begin
        cand_q  <= sync2;
        cnt_q   <= '0;
        state_q <= StFilt;
      end else if (state_q == StFilt) begin
        if (cnt_q != CntMax) begin
          cnt_q <= cnt_q + CntW'(1);
        end else if (lc_tx_valid(cand_q)) begin
          acc_q   <= cand_q;
          err_q   <= 1'b0;
          chg_q   <= (cand_q != acc_q);
          state_q <= StIdle;
        end else begin
          // Never pass an unknown encoding through; park on Off and flag it.
          acc_q   <= Off;
          err_q   <= 1'b1;
          chg_q   <= (acc_q != Off);
          state_q <= StErr;
        end
      end
    end
  end

  // Every output copy fans out from the single accepted-value register.
  for (genvar c = 0; c < NumCopies; c++) begin : gen_copies
    for (genvar b = 0; b < TxWidth; b++) begin : gen_bits
      caliptra_prim_sec_anchor_buf #(
        .Width (1)
      ) u_buf (
        .din  (acc_q[b]),
        .dout (lc_en_o[c][b])
      );
    end
  end

  assign err_o = err_q;
  assign chg_o = chg_q;

endmodule

// File: tb/tb_caliptra_prim_lc_sync_filt.sv
// Directed self-checking bench for caliptra_prim_lc_sync_filt.
module tb_caliptra_prim_lc_sync_filt;

  localparam logic [3:0] ON   = 4'b0101;
  localparam logic [3:0] OFF  = 4'b1010;
  localparam int         LAT  = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut_a: 3 copies, resets to Off. dut_b: 1 copy, resets to On.
  logic            rst_a, err_a, chg_a;
  logic [3:0]      en_a;
  logic [2:0][3:0] out_a;
  logic            rst_b, err_b, chg_b;
  logic [3:0]      en_b;
  logic [0:0][3:0] out_b;

  int n_checks = 0;
  int n_fail   = 0;

  caliptra_prim_lc_sync_filt #(
    .NumCopies      (3),
    .FiltCycles     (4),
    .ResetValueIsOn (1'b0)
  ) dut_a (
    .clk_i   (clk),
    .rst_i   (rst_a),
    .lc_en_i (en_a),
    .lc_en_o (out_a),
    .err_o   (err_a),
    .chg_o   (chg_a)
  );

  caliptra_prim_lc_sync_filt #(
    .NumCopies      (1),
    .FiltCycles     (4),
    .ResetValueIsOn (1'b1)
  ) dut_b (
    .clk_i   (clk),
    .rst_i   (rst_b),
    .lc_en_i (en_b),
    .lc_en_o (out_b),
    .err_o   (err_b),
    .chg_o   (chg_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic bad;
    rst_a = 1'b1;
    en_a  = OFF;
    step();
    step();
    bad = 1'b0;
    for (int c = 0; c < 3; c++) if (out_a[c] !== OFF) bad = 1'b1;
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL reset_out: got %h want %h", out_a, {3{OFF}});
    end
    n_checks++;
    if (err_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err: got %b want 0", err_a);
    end
    n_checks++;
    if (chg_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_chg: got %b want 0", chg_a);
    end
  endtask

  // Release reset and present On on the same cycle; On must appear after edge 7.
  task automatic test_latency();
    logic [3:0] exp_out;
    logic       bad;
    rst_a = 1'b0;
    en_a  = ON;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_out = (k >= LAT) ? ON : OFF;
      bad = 1'b0;
      for (int c = 0; c < 3; c++) if (out_a[c] !== exp_out) bad = 1'b1;
      n_checks++;
      if (bad) begin
        n_fail++;
        $display("FAIL latency_out k=%0d: got %h want %h", k, out_a, {3{exp_out}});
      end
      n_checks++;
      if (chg_a !== (k == LAT)) begin
        n_fail++;
        $display("FAIL latency_chg k=%0d: got %b want %b", k, chg_a, (k == LAT));
      end
      n_checks++;
      if (err_a !== 1'b0) begin
        n_fail++;
        $display("FAIL latency_err k=%0d: got %b want 0", k, err_a);
      end
    end
  endtask

  // Return to Off, then a 3-cycle On pulse must be filtered away entirely.
  task automatic test_glitch();
    logic [3:0] exp_out;
    logic       exp_chg;
    en_a = OFF;
    for (int k = 1; k <= 25; k++) begin
      if (k == 11) en_a = ON;
      if (k == 14) en_a = OFF;
      step();
      exp_out = (k < LAT) ? ON : OFF;
      exp_chg = (k == LAT);
      n_checks++;
      if (out_a[0] !== exp_out || chg_a !== exp_chg) begin
        n_fail++;
        $display("FAIL glitch k=%0d: got out=%h chg=%b want out=%h chg=%b",
                 k, out_a[0], chg_a, exp_out, exp_chg);
      end
    end
  endtask

  // From Off: accept On, then 0000 (err), then 1111 (still err, no chg), then On.
  task automatic test_invalid();
    logic [3:0] vals   [4];
    logic [3:0] prev_o [4];
    logic [3:0] next_o [4];
    logic       prev_e [4];
    logic       next_e [4];
    logic [3:0] exp_out;
    logic       exp_err;
    logic       exp_chg;
    vals   = '{ON,  4'b0000, 4'b1111, ON};
    prev_o = '{OFF, ON,      OFF,     OFF};
    next_o = '{ON,  OFF,     OFF,     ON};
    prev_e = '{1'b0, 1'b0,   1'b1,    1'b1};
    next_e = '{1'b0, 1'b1,   1'b1,    1'b0};
    for (int p = 0; p < 4; p++) begin
      en_a = vals[p];
      for (int k = 1; k <= 10; k++) begin
        step();
        exp_out = (k < LAT) ? prev_o[p] : next_o[p];
        exp_err = (k < LAT) ? prev_e[p] : next_e[p];
        exp_chg = (k == LAT) && (prev_o[p] != next_o[p]);
        n_checks++;
        if (out_a[0] !== exp_out || err_a !== exp_err || chg_a !== exp_chg) begin
          n_fail++;
          $display("FAIL invalid p=%0d k=%0d: got out=%h err=%b chg=%b want out=%h err=%b chg=%b",
                   p, k, out_a[0], err_a, chg_a, exp_out, exp_err, exp_chg);
        end
      end
    end
  endtask

  // Toggle every 8 cycles from accepted On; copies must agree and one chg per toggle.
  task automatic test_toggle();
    logic [3:0] cur;
    logic [3:0] prev;
    logic [3:0] exp_out;
    logic       bad;
    int         pulses;
    cur    = ON;
    pulses = 0;
    for (int t = 0; t < 4; t++) begin
      prev = cur;
      cur  = (prev == ON) ? OFF : ON;
      en_a = cur;
      for (int k = 1; k <= 8; k++) begin
        step();
        if (chg_a === 1'b1) pulses++;
        exp_out = (k < LAT) ? prev : cur;
        bad = 1'b0;
        for (int c = 0; c < 3; c++) if (out_a[c] !== exp_out) bad = 1'b1;
        n_checks++;
        if (bad) begin
          n_fail++;
          $display("FAIL toggle_out t=%0d k=%0d: got %h want %h", t, k, out_a, {3{exp_out}});
        end
      end
    end
    n_checks++;
    if (pulses != 4) begin
      n_fail++;
      $display("FAIL toggle_pulses: got %0d want 4", pulses);
    end
  endtask

  // Reset mid-filter on dut_b (reset value On), then Off needs the full latency.
  task automatic test_reset_mid();
    logic [3:0] exp_out;
    rst_b = 1'b1;
    en_b  = OFF;
    step();
    n_checks++;
    if (out_b[0] !== ON || err_b !== 1'b0 || chg_b !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_b_init: got out=%h err=%b chg=%b want out=%h err=0 chg=0",
               out_b[0], err_b, chg_b, ON);
    end
    rst_b = 1'b0;
    for (int k = 1; k <= 8; k++) step();
    n_checks++;
    if (out_b[0] !== OFF) begin
      n_fail++;
      $display("FAIL rst_b_off: got %h want %h", out_b[0], OFF);
    end
    // Five edges: sync1, sync2, candidate load (cnt 0), cnt 1, cnt 2.
    en_b = ON;
    for (int k = 1; k <= 5; k++) step();
    rst_b = 1'b1;
    step();
    n_checks++;
    if (out_b[0] !== ON || chg_b !== 1'b0 || err_b !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: got out=%h chg=%b err=%b want out=%h chg=0 err=0",
               out_b[0], chg_b, err_b, ON);
    end
    rst_b = 1'b0;
    en_b  = OFF;
    for (int k = 1; k <= 9; k++) begin
      step();
      exp_out = (k < LAT) ? ON : OFF;
      n_checks++;
      if (out_b[0] !== exp_out || chg_b !== (k == LAT)) begin
        n_fail++;
        $display("FAIL rst_mid_refilt k=%0d: got out=%h chg=%b want out=%h chg=%b",
                 k, out_b[0], chg_b, exp_out, (k == LAT));
      end
    end
  endtask

  initial begin
    rst_a = 1'b1;
    en_a  = OFF;
    rst_b = 1'b1;
    en_b  = OFF;
    test_reset();
    test_latency();
    test_glitch();
    test_invalid();
    test_toggle();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/caliptra_prim_lc_sync_filt.md
CALIPTRA_PRIM_LC_SYNC_FILT -- requirements
Module: caliptra_prim_lc_sync_filt

Interface
REQ-001 Parameter NumCopies, default 1, number of identical lc_tx_t output copies; SHALL be >= 1.
REQ-002 Parameter FiltCycles, default 4, consecutive synchronized cycles a value must hold before acceptance; SHALL be >= 1 (elaboration assertion).
REQ-003 Parameter ResetValueIsOn, default 0, reset value of all state: 0 = lc_ctrl_pkg::Off, 1 = lc_ctrl_pkg::On.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk_i  input  1  sole clock; all flops rising-edge.
REQ-006 rst_i  input  1  synchronous active-high reset.
REQ-007 lc_en_i  input  lc_ctrl_pkg::TxWidth (lc_tx_t)  multibit enable from a remote sender, asynchronous to clk_i.
REQ-008 lc_en_o  output  NumCopies x TxWidth  accepted value, identical in every copy.
REQ-009 err_o  output  1  high while the accepted value came from an invalid encoding (neither On nor Off).
REQ-010 chg_o  output  1  single-cycle pulse when the accepted value changes.

Function
REQ-011 Each lc_en_i bit SHALL pass through two synchronizer flops (sync1, sync2) before any other logic.
REQ-012 A candidate register cand_q and counter cnt_q (width $clog2(FiltCycles+1)) SHALL track sync2.
REQ-013 FSM states: IDLE (cand_q equals accepted value, no count), FILT (counting), ERR (accepted value was invalid, no count).
REQ-014 Any state, sync2 != cand_q: cand_q <= sync2, cnt_q <= 0, next state FILT.
REQ-015 FILT, sync2 == cand_q, cnt_q < FiltCycles-1: cnt_q increments by 1.
REQ-016 FILT, sync2 == cand_q, cnt_q == FiltCycles-1: accept on that edge; cand_q On/Off -> accepted value = cand_q, err cleared, next IDLE; otherwise accepted value = Off, err set, next ERR.
REQ-017 Counter SHALL saturate and never wrap; any mismatch restarts the count at 0 (glitch of any length < FiltCycles is discarded).
REQ-018 lc_en_o, err_o, chg_o SHALL be direct flop outputs (no combinational path from lc_en_i).
REQ-019 Latency: an input change held stable appears on lc_en_o after FiltCycles+3 rising edges, counting the first sampling edge as edge 1 (7 with FiltCycles=4).
REQ-020 chg_o SHALL pulse high for exactly one cycle, coincident with the first cycle lc_en_o shows a new value; accepting an identical value produces no pulse.
REQ-021 err_o SHALL stay high until a valid On/Off value is accepted; repeated invalid acceptance keeps lc_en_o = Off, no chg_o.
REQ-022 Invalid input SHALL never produce On at lc_en_o (fail-safe to Off).

Reset
REQ-023 rst_i sampled high SHALL set sync1, sync2, cand_q, accepted value to ResetValue; cnt_q=0; state IDLE; err_o=0; chg_o=0; visible after that edge.
REQ-024 Reset during FILT SHALL discard the pending candidate; no chg_o pulse on reset or on its release.

Structure
REQ-025 lc_tx_t, TxWidth, On, Off SHALL come from lc_ctrl_pkg; FSM state enum is local to the module.
REQ-026 The two-flop synchronizer SHALL be one sub-module, caliptra_prim_lc_sync_2flop (Width, ResetValue parameters, synchronous active-high reset).
REQ-027 Output copies SHALL be driven from one accepted-value register through per-bit caliptra_prim_sec_anchor_buf instances.

Verification
REQ-028 Reset, FiltCycles=4, ResetValueIsOn=0, lc_en_i=On at edge 1 -> lc_en_o=Off through edge 6, On after edge 7, chg_o high one cycle, err_o=0.
REQ-029 lc_en_i=Off steady, 3-cycle pulse to On -> lc_en_o stays Off, chg_o never pulses.
REQ-030 lc_en_i=4'b0000 held 10 cycles from accepted On -> lc_en_o=Off, err_o=1, chg_o one pulse; then On held -> lc_en_o=On, err_o=0.
REQ-031 rst_i asserted mid-FILT (cnt_q=2) toward On, ResetValueIsOn=1 -> lc_en_o=On next edge, cnt_q=0, no chg_o; input Off then needs full FiltCycles+3 edges.
REQ-032 NumCopies=3, toggle On/Off every 8 cycles -> all copies equal every cycle, one chg_o per toggle.
